sdcard_respmod: RTL
===================

SDCARD_RESPMOD -- requirements
Module: sdcard_respmod

Interface
REQ-001 Parameter NCR, default 1: number of 0xFF filler bytes between the command CRC byte and the R1 response.
REQ-002 Parameter TBUSY, default 4: number of 0x00 busy bytes sent after a write data-response.
REQ-003 Port CLOCK, input, 1: sole clock; all logic on the rising edge.
REQ-004 Port RESET, input, 1: asynchronous, active-low reset.
REQ-005 Port SD_NCS, input, 1: host chip select, active low.
REQ-006 Port iDone, input, 1: one-cycle pulse from the slave SPI byte engine when a byte exchange completes.
REQ-007 Port iData, input, 8: byte received from the host; valid while iDone=1.
REQ-008 Port oData, output, 8: byte to return on the next exchange.
REQ-009 Port oEn, output, 2: [1] store-write strobe, [0] store-read strobe; each is a one-cycle pulse.
REQ-010 Port oAddr, output, 23: sector address, taken from command argument bits [31:9].
REQ-011 Port iDataFF, input, 8: store read data, valid the cycle after an oEn[0] pulse.
REQ-012 Port oDataFF, output, 8: store write data, valid while oEn[1]=1.
REQ-013 Port oTag, output, 8: 2'b01 followed by the 6-bit index of the last completed command.
REQ-014 Port oDone, output, 1: one-cycle pulse when a command sequence completes.

Function
REQ-015 States: IDLE, CMD, NCR, R1, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY, DONE.
REQ-016 IDLE: oData=0xFF; a received byte matching 01xxxxxx starts a command, goes to CMD, and is stored as byte 0.
REQ-017 CMD: collect 5 more bytes (argument MSB first, then CRC); after the 6th byte go to NCR.
REQ-018 NCR: send NCR bytes of 0xFF; then R1 presents the response byte on oData for one exchange.
REQ-019 R1 value: bit0 = idle flag; bit2 = illegal command; bit3 = CRC error (macro only); all other bits 0.
REQ-020 CMD0: set idle flag; R1=0x01; go to DONE.
REQ-021 CMD1: clear idle flag; R1=0x00; go to DONE.
REQ-022 CMD17 or CMD24 while idle, or any other index: R1=0x04|idle; no data phase; go to DONE.
REQ-023 CMD17 not idle: R1=0x00; latch oAddr; send one 0xFF byte, then token 0xFE, then 512 store bytes, then two 0xFF CRC bytes; then DONE.
REQ-024 CMD17 store timing: pulse oEn[0] once per data byte, at least 2 cycles before that byte is loaded into oData.
REQ-025 CMD24 not idle: R1=0x00; latch oAddr; in WR_TOKEN, discard bytes until 0xFE is received.
REQ-026 CMD24 data: in WR_DATA, each received byte drives oDataFF with a one-cycle oEn[1] pulse in the iDone cycle; 512 bytes.
REQ-027 CMD24 completion: receive 2 CRC bytes (ignored), send 0x05, send TBUSY bytes of 0x00, send 0xFF, then DONE.
REQ-028 oData SHALL be updated within 2 CLOCK cycles of iDone; the byte engine requires SCK <= CLOCK/4.
REQ-029 DONE: update oTag, pulse oDone, return to IDLE.
REQ-030 Byte counter is 10 bits, compared against 511; no wrap beyond 511.
REQ-031 iDone while SD_NCS=1 is ignored.
REQ-032 SD_NCS rising mid-sequence: abort to IDLE next cycle; oData=0xFF; no oDone; no further oEn; idle flag unchanged.
REQ-033 iDone coinciding with SD_NCS rising: abort takes priority; the byte is discarded.

Reset
REQ-034 Reset values: oData=0xFF, oEn=0, oAddr=0, oDataFF=0, oTag=0, oDone=0, idle flag=1, state=IDLE, counters=0.

Configuration
REQ-035 Macro SDCARD_RESP_CRC7_EN defined: CMD0 CRC7 is checked over bytes 0-4 (polynomial x^7+x^3+1, byte = {crc7,1}). On mismatch: R1=0x08|idle, command not executed, oTag unchanged.
REQ-036 Macro SDCARD_RESP_CRC7_EN undefined: the CRC byte is ignored for all commands and no CRC logic is instantiated.

Structure
REQ-037 Shared package sdcard_pkg holds: state encoding; command indices 0, 1, 17, 24; token 0xFE; data-response 0x05; R1 bit positions.
REQ-038 Optional sub-module sdcard_crc7 (serial-per-byte CRC7), instantiated only under the macro.

Verification
REQ-039 Reset, then CMD0 40 00 00 00 00 95 -> one 0xFF, then R1=0x01, oTag=0x40, one oDone pulse.
REQ-040 CMD17 before CMD1 -> R1=0x05, no oEn pulses; after CMD1 (R1=0x00), CMD17 arg 0x00000200 -> oAddr=1, FE, 512 bytes matching store, FF FF, oTag=0x51.
REQ-041 CMD24 arg 0x00000400, 3 fill bytes, FE, 512 bytes, 2 CRC -> 512 oEn[1] pulses with matching data, oAddr=2, responses 05, 00x4, FF, oTag=0x58.
REQ-042 SD_NCS deasserted after data byte 100 of CMD17 -> IDLE, oData=0xFF, no oDone; a following CMD0 completes normally.
REQ-043 Macro on, CMD0 with CRC byte 0x94 -> R1=0x09, no oDone tag change; macro off -> R1=0x01.
REQ-044 CMD8 -> R1=0x04|idle, oTag=0x48.

Source files
------------

// File: rtl/sdcard_pkg.sv
// rtl/sdcard_pkg.sv - shared states, command codes, tokens and CRC7 helper for the SD response model
package sdcard_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_CMD, ST_NCR, ST_R1,
        ST_RD_TOKEN, ST_RD_DATA, ST_RD_CRC,
        ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC, ST_WR_RESP, ST_WR_BUSY,
        ST_DONE
    } state_t;

    localparam logic [5:0] CMD_GO_IDLE      = 6'd0;
    localparam logic [5:0] CMD_SEND_OP      = 6'd1;
    localparam logic [5:0] CMD_READ_SINGLE  = 6'd17;
    localparam logic [5:0] CMD_WRITE_SINGLE = 6'd24;

    localparam logic [7:0] TOKEN_START  = 8'hFE;
    localparam logic [7:0] DATA_RESP_OK = 8'h05;
    localparam logic [7:0] FILL         = 8'hFF;

    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;
    localparam int R1_CRC_BIT     = 3;

    localparam logic [9:0] LAST_BYTE = 10'd511;

    // MSB-first CRC7, polynomial x^7 + x^3 + 1
    function automatic logic [6:0] crc7Byte(input logic [6:0] crcIn, input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crcIn;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

endpackage

// File: rtl/sdcard_crc7.sv
// rtl/sdcard_crc7.sv - byte-serial CRC7 accumulator over command bytes
module sdcard_crc7
    import sdcard_pkg::*;
(
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       init,
    input  logic       en,
    input  logic [7:0] data,
    output logic [6:0] crc
);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7Byte(init ? 7'd0 : crc, data);
        end
    end

endmodule

// File: rtl/sdcard_respmod.sv
// rtl/sdcard_respmod.sv - SPI-mode SD card response engine (CMD0/1/17/24); SDCARD_RESP_CRC7_EN enables CMD0 CRC7 check
module sdcard_respmod
    import sdcard_pkg::*;
#(
    parameter int NCR   = 1,
    parameter int TBUSY = 4
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        SD_NCS,
    input  logic        iDone,
    input  logic [7:0]  iData,
    output logic [7:0]  oData,
    output logic [1:0]  oEn,
    output logic [22:0] oAddr,
    input  logic [7:0]  iDataFF,
    output logic [7:0]  oDataFF,
    output logic [7:0]  oTag,
    output logic        oDone
);

    localparam logic [9:0] NCR_LAST  = 10'(NCR - 1);
    localparam logic [9:0] BUSY_LAST = 10'(TBUSY);

    state_t      state;
    state_t      afterR1;
    state_t      afterR1Next;
    logic [9:0]  cnt;
    logic [5:0]  cmdIdx;
    logic [22:0] argAddr;
    logic [7:0]  r1;
    logic [7:0]  r1Next;
    logic [7:0]  rdBuf;
    logic        idleFlag;
    logic        rdPend;
    logic        crcOk;
    logic        byteIn;

    assign byteIn = iDone && !SD_NCS;

`ifdef SDCARD_RESP_CRC7_EN
    logic [6:0] crc7;

    sdcard_crc7 uCrc7 (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .init  (state == ST_IDLE),
        .en    (byteIn && ((state == ST_IDLE) || (state == ST_CMD && cnt < 10'd5))),
        .data  (iData),
        .crc   (crc7)
    );

    assign crcOk = (cmdIdx != CMD_GO_IDLE) || (iData == {crc7, 1'b1});
`else
    assign crcOk = 1'b1;
`endif

    // Decode is evaluated while the CRC byte is on iData
    always_comb begin
        r1Next      = 8'h00;
        afterR1Next = ST_DONE;
        if (!crcOk) begin
            r1Next[R1_CRC_BIT]  = 1'b1;
            r1Next[R1_IDLE_BIT] = idleFlag;
            afterR1Next         = ST_IDLE;
        end else begin
            case (cmdIdx)
                CMD_GO_IDLE: r1Next[R1_IDLE_BIT] = 1'b1;
                CMD_SEND_OP: r1Next = 8'h00;
                CMD_READ_SINGLE, CMD_WRITE_SINGLE: begin
                    if (idleFlag) begin
                        r1Next[R1_ILLEGAL_BIT] = 1'b1;
                        r1Next[R1_IDLE_BIT]    = 1'b1;
                    end else begin
                        afterR1Next = (cmdIdx == CMD_READ_SINGLE) ? ST_RD_TOKEN : ST_WR_TOKEN;
                    end
                end
                default: begin
                    r1Next[R1_ILLEGAL_BIT] = 1'b1;
                    r1Next[R1_IDLE_BIT]    = idleFlag;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            afterR1  <= ST_DONE;
            cnt      <= '0;
            cmdIdx   <= '0;
            argAddr  <= '0;
            r1       <= '0;
            rdBuf    <= '0;
            idleFlag <= 1'b1;
            rdPend   <= 1'b0;
            oData    <= FILL;
            oEn      <= 2'b00;
            oAddr    <= '0;
            oDataFF  <= '0;
            oTag     <= '0;
            oDone    <= 1'b0;
        end else begin
            oEn    <= 2'b00;
            oDone  <= 1'b0;
            rdPend <= oEn[0];
            if (rdPend) begin
                rdBuf <= iDataFF;
            end

            if (SD_NCS && state != ST_IDLE && state != ST_DONE) begin
                state <= ST_IDLE;
                oData <= FILL;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (byteIn && iData[7:6] == 2'b01) begin
                            cmdIdx <= iData[5:0];
                            cnt    <= 10'd1;
                            state  <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (byteIn) begin
                            // Only argument bits [31:9] are kept: the sector address
                            if (cnt == 10'd1 || cnt == 10'd2) begin
                                argAddr <= {argAddr[14:0], iData};
                            end else if (cnt == 10'd3) begin
                                argAddr <= {argAddr[15:0], iData[7:1]};
                            end
                            if (cnt == 10'd5) begin
                                r1      <= r1Next;
                                afterR1 <= afterR1Next;
                                cnt     <= '0;
                                if (afterR1Next == ST_RD_TOKEN || afterR1Next == ST_WR_TOKEN) begin
                                    oAddr <= argAddr;
                                end
                                if (NCR == 0) begin
                                    state <= ST_R1;
                                    oData <= r1Next;
                                end else begin
                                    state <= ST_NCR;
                                    oData <= FILL;
                                end
                            end else begin
                                cnt <= cnt + 10'd1;
                            end
                        end
                    end
                    ST_NCR: begin
                        if (byteIn) begin
                            if (cnt == NCR_LAST) begin
                                state <= ST_R1;
                                oData <= r1;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 10'd1;
                            end
                        end
                    end
                    ST_R1: begin
                        if (byteIn) begin
                            state <= afterR1;
                            oData <= FILL;
                            cnt   <= '0;
                            if (afterR1 == ST_RD_TOKEN) begin
                                oEn[0] <= 1'b1;
                            end
                        end
                    end
                    ST_RD_TOKEN: begin
                        if (byteIn) begin
                            if (cnt == 10'd0) begin
                                oData <= TOKEN_START;
                                cnt   <= 10'd1;
                            end else begin
                                oData  <= rdBuf;
                                oEn[0] <= 1'b1;
                                cnt    <= '0;
                                state  <= ST_RD_DATA;
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        // Each load fetches the byte after next, keeping one exchange of slack
                        if (byteIn) begin
                            if (cnt == LAST_BYTE) begin
                                state <= ST_RD_CRC;
                                oData <= FILL;
                                cnt   <= '0;
                            end else begin
                                oData <= rdBuf;
                                cnt   <= cnt + 10'd1;
                                if (cnt < LAST_BYTE - 10'd1) begin
                                    oEn[0] <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_RD_CRC: begin
                        if (byteIn) begin
                            if (cnt == 10'd1) begin
                                state <= ST_DONE;
                            end else begin
                                cnt <= 10'd1;
                            end
                        end
                    end
                    ST_WR_TOKEN: begin
                        if (byteIn && iData == TOKEN_START) begin
                            state <= ST_WR_DATA;
                            cnt   <= '0;
                        end
                    end
                    ST_WR_DATA: begin
                        if (byteIn) begin
                            oDataFF <= iData;
                            oEn[1]  <= 1'b1;
                            if (cnt == LAST_BYTE) begin
                                state <= ST_WR_CRC;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 10'd1;
                            end
                        end
                    end
                    ST_WR_CRC: begin
                        if (byteIn) begin
                            if (cnt == 10'd1) begin
                                state <= ST_WR_RESP;
                                oData <= DATA_RESP_OK;
                                cnt   <= '0;
                            end else begin
                                cnt <= 10'd1;
                            end
                        end
                    end
                    ST_WR_RESP: begin
                        if (byteIn) begin
                            state <= ST_WR_BUSY;
                            cnt   <= '0;
                            oData <= (TBUSY == 0) ? FILL : 8'h00;
                        end
                    end
                    ST_WR_BUSY: begin
                        if (byteIn) begin
                            if (cnt == BUSY_LAST) begin
                                state <= ST_DONE;
                            end else begin
                                cnt   <= cnt + 10'd1;
                                oData <= (cnt + 10'd1 == BUSY_LAST) ? FILL : 8'h00;
                            end
                        end
                    end
                    ST_DONE: begin
                        oTag  <= {2'b01, cmdIdx};
                        oDone <= 1'b1;
                        if (cmdIdx == CMD_GO_IDLE) begin
                            idleFlag <= 1'b1;
                        end else if (cmdIdx == CMD_SEND_OP) begin
                            idleFlag <= 1'b0;
                        end
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        oData <= FILL;
                    end
                endcase
            end
        end
    end

endmodule
